fp32_mul_post: RTL and testbench

Registered post-processing stage directly downstream of the combinational radix-4 Booth FP32 multiplier. It takes the multiplier's packed result and overflow flag plus the two original operands. It resolves special cases (zero, infinity, NaN) and exponent overflow/underflow, then queues the corrected IEEE-754 single-precision result in a small FIFO with a valid/ready handshake. It also keeps sticky exception flags for the surrounding datapath controller.

---
 rtl/fp32_mul_post_if.sv | 24 ++
 rtl/fp32_mul_post.sv | 154 +++++++++++++++
 tb/tb_fp32_mul_post.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_mul_post_if.sv
// Handshake bundle between the Booth multiplier output, this post stage and the consumer.
// The master side drives operands and out_ready; the slave side is the post stage.
interface fp32_mul_post_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] mul_result;
  logic        mul_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_exc;

  modport master (
    output in_valid, a_i, b_i, mul_result, mul_overflow, out_ready,
    input  in_ready, out_valid, out_data, out_exc
  );

  modport slave (
    input  in_valid, a_i, b_i, mul_result, mul_overflow, out_ready,
    output in_ready, out_valid, out_data, out_exc
  );
endinterface

// File: rtl/fp32_mul_post.sv
// Generic synchronous circular-buffer FIFO used by the FP32 multiplier post stage.
// Latency: a push is visible at the head one cycle later (no empty bypass).
// Backpressure: full blocks pushes even when a pop happens in the same cycle.
module fp32_mul_post_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdat,
  input  logic             pop,
  output logic [WIDTH-1:0] rdat,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdat    = mem[rd_ptr];

  // Storage is left unreset; the consumer gates the head while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// FP32 multiplier post stage: special-case/exponent fix-up, result FIFO, sticky flags.
// Latency: result at FIFO head in the cycle after the accepting edge; 1/cycle throughput.
// Backpressure: in_ready = !full, independent of out_ready; head held while !out_ready.
module fp32_mul_post #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  fp32_mul_post_if.slave         bus,
  input  logic                   flag_clr,
  output logic [2:0]             sticky_flags,
  output logic [$clog2(DEPTH):0] count
);
  typedef struct packed {
    logic [2:0]  exc;
    logic [31:0] data;
  } entry_t;

  entry_t            in_ent;
  entry_t            head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [7:0]        ea;
  logic [7:0]        eb;
  logic              s;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              n;
  logic signed [9:0] es;
  logic signed [9:0] ef;
  logic              unused_bits;

  assign unused_bits = ^{bus.mul_overflow, bus.mul_result[31]};

  assign ea     = bus.a_i[30:23];
  assign eb     = bus.b_i[30:23];
  assign s      = bus.a_i[31] ^ bus.b_i[31];
  assign a_nan  = (ea == 8'hFF) && (bus.a_i[22:0] != '0);
  assign b_nan  = (eb == 8'hFF) && (bus.b_i[22:0] != '0);
  assign a_inf  = (ea == 8'hFF) && (bus.a_i[22:0] == '0);
  assign b_inf  = (eb == 8'hFF) && (bus.b_i[22:0] == '0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  // The multiplier's normalisation shift shows up as a +1 on its exponent field.
  assign es = signed'({2'b00, ea}) + signed'({2'b00, eb}) - 10'sd127;
  assign n  = (bus.mul_result[30:23] != es[7:0]);
  assign ef = es + signed'({9'b0, n});

  always_comb begin
    in_ent.exc  = 3'b000;
    in_ent.data = {s, ef[7:0], bus.mul_result[22:0]};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      in_ent.exc  = 3'b100;
      in_ent.data = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      in_ent.data = {s, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      in_ent.data = {s, 31'h0};
    end else if (ef >= 10'sd255) begin
      in_ent.exc  = 3'b010;
      in_ent.data = {s, 8'hFF, 23'h0};
    end else if (ef <= 10'sd0) begin
      in_ent.exc  = 3'b001;
      in_ent.data = {s, 31'h0};
    end
  end

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  fp32_mul_post_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdat  (in_ent),
    .pop   (pop),
    .rdat  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? 32'h0 : head.data;
  assign bus.out_exc   = empty ? 3'b0  : head.exc;

  // A clear in the same cycle as a flagged push leaves only that push's flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= 3'b000;
    end else begin
      sticky_flags <= (flag_clr ? 3'b000 : sticky_flags) | (push ? in_ent.exc : 3'b000);
    end
  end
endmodule

// File: tb/tb_fp32_mul_post.sv
// Randomized scoreboard bench for fp32_mul_post against an arithmetic reference model.
module tb_fp32_mul_post;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flag_clr = 1'b0;
  logic [2:0] sticky_flags;
  logic [2:0] count;

  fp32_mul_post_if bus ();

  fp32_mul_post #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .flag_clr     (flag_clr),
    .sticky_flags (sticky_flags),
    .count        (count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  logic [34:0] sb[$];
  int          occ = 0;
  logic [2:0]  st_model = 3'b000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: IEEE single-precision product with flush-to-zero and truncated fraction.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, e;
    logic        s;
    logic        an, bn, ai, bi, az, bz;
    logic [47:0] p;
    logic [22:0] frac;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {3'b100, 32'h7FC0_0000};
    if (ai || bi) return {3'b000, s, 8'hFF, 23'h0};
    if (az || bz) return {3'b000, s, 31'h0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = ea + eb - 127 + (p[47] ? 1 : 0);
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b001, s, 31'h0};
    frac = p[47] ? p[46:24] : p[45:23];
    return {3'b000, s, e[7:0], frac};
  endfunction

  // What the upstream multiplier would present: truncated product, wrapped exponent, junk sign.
  function automatic logic [31:0] gen_mr(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    int          e;
    logic [31:0] r;
    r = $urandom;
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      return r;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127 + (p[47] ? 1 : 0);
    r[30:23] = e[7:0];
    r[22:0]  = p[47] ? p[46:24] : p[45:23];
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    int          r;
    logic [7:0]  e;
    logic [22:0] f;
    r = $urandom_range(0, 15);
    f = 23'($urandom);
    if (r == 0)      e = 8'h00;
    else if (r == 1) e = 8'hFF;
    else if (r < 4)  e = 8'($urandom_range(1, 6));
    else if (r < 6)  e = 8'($urandom_range(248, 254));
    else             e = 8'($urandom_range(90, 165));
    if (e == 8'hFF && $urandom_range(0, 1) == 1) f = '0;
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input bit clr, input bit ordy, output bit acc);
    logic [34:0] e;
    bit          pop;
    @(posedge clk);
    #1;
    bus.in_valid     = v;
    bus.a_i          = a;
    bus.b_i          = b;
    bus.mul_result   = gen_mr(a, b);
    bus.mul_overflow = 1'($urandom_range(0, 1));
    flag_clr         = clr;
    bus.out_ready    = ordy;
    @(negedge clk);
    chk("count", 32'(count), 32'(occ));
    chk("in_ready", 32'(bus.in_ready), 32'(occ < DEPTH));
    chk("sticky", 32'(sticky_flags), 32'(st_model));
    acc = v && (occ < DEPTH);
    e   = model(a, b);
    if (acc) sb.push_back(e);
    pop      = (occ > 0) && ordy;
    st_model = (clr ? 3'b000 : st_model) | (acc ? e[34:32] : 3'b000);
    occ      = occ + int'(acc) - int'(pop);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    flag_clr      = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    occ      = 0;
    st_model = 3'b000;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_exc", 32'(bus.out_exc), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
  endtask

  // Monitor: compares every consumed head against the oldest expected entry.
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got data 0x%08h exc %03b with nothing expected",
                   bus.out_data, bus.out_exc);
        end else begin
          e = sb.pop_front();
          if (bus.out_data !== e[31:0] || bus.out_exc !== e[34:32]) begin
            fails++;
            $display("FAIL sb_result: got data 0x%08h exc %03b expected data 0x%08h exc %03b",
                     bus.out_data, bus.out_exc, e[31:0], e[34:32]);
          end
        end
      end else if (!rst && !bus.out_valid) begin
        chk("empty_gating", {bus.out_data[31:3], bus.out_data[2:0] | bus.out_exc}, 32'd0);
      end
    end
  end

  initial begin
    bit acc;
    bus.in_valid     = 1'b0;
    bus.a_i          = '0;
    bus.b_i          = '0;
    bus.mul_result   = '0;
    bus.mul_overflow = 1'b0;
    bus.out_ready    = 1'b0;
    do_reset();

    cycle(1, 32'h4000_0000, 32'h4040_0000, 0, 0, acc);
    cycle(0, 32'h0, 32'h0, 0, 0, acc);
    chk("dir_count1", 32'(count), 32'd1);
    chk("dir_2x3_head", bus.out_data, 32'h40C0_0000);
    cycle(0, 32'h0, 32'h0, 0, 1, acc);

    cycle(1, 32'h7F00_0000, 32'h7F00_0000, 0, 1, acc);
    cycle(1, 32'hFF00_0000, 32'h7F00_0000, 0, 1, acc);
    cycle(1, 32'h8080_0000, 32'h0080_0000, 0, 1, acc);
    cycle(1, 32'h7F80_0000, 32'h0000_0000, 0, 1, acc);
    cycle(1, 32'h7F80_0000, 32'h3F80_0000, 0, 1, acc);
    cycle(1, 32'h7FC0_0001, rand_op(), 0, 1, acc);
    repeat (3) cycle(0, 32'h0, 32'h0, 0, 1, acc);
    chk("sticky_all", 32'(sticky_flags), 32'b111);

    cycle(1, 32'h7F00_0000, 32'h7F00_0000, 1, 1, acc);
    cycle(0, 32'h0, 32'h0, 0, 1, acc);
    chk("clr_set_wins", 32'(sticky_flags), 32'b010);
    cycle(0, 32'h0, 32'h0, 1, 1, acc);
    cycle(0, 32'h0, 32'h0, 0, 1, acc);
    chk("clr_only", 32'(sticky_flags), 32'b000);

    for (int i = 0; i < 5; i++) cycle(1, rand_op(), rand_op(), 0, 0, acc);
    chk("full_5th_rejected", 32'(acc), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 12; i++) cycle(1, rand_op(), rand_op(), 0, 1, acc);
    chk("steady_count", 32'(count), 32'd3);

    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 9) < 7, rand_op(), rand_op(), $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7, acc);

    for (int i = 0; i < 20 && occ > 0; i++) cycle(0, 32'h0, 32'h0, 0, 1, acc);
    cycle(1, 32'h7F00_0000, 32'h7F00_0000, 0, 0, acc);
    cycle(1, rand_op(), rand_op(), 0, 0, acc);
    cycle(1, rand_op(), rand_op(), 0, 0, acc);
    cycle(0, 32'h0, 32'h0, 0, 0, acc);
    chk("pre_rst_count", 32'(count), 32'd3);
    do_reset();

    cycle(1, 32'h3F80_0000, 32'h3F80_0000, 0, 1, acc);
    for (int i = 0; i < 50 && occ > 0; i++) cycle(0, 32'h0, 32'h0, 0, 1, acc);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results never appeared, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
